// File: rtl/control_fsm_if.sv
// Datapath control bus between control_fsm and the PC / IR / register file /
// data memory / ALU. The FSM owns the master side and drives every control
// line. IR is the only datapath input to the FSM (plus Step when the
// CTRL_STEP_EN single-step build option is defined).
interface control_fsm_if #(
  parameter int D_ADDR_W = 8
);
  logic [15:0]         IR;
`ifdef CTRL_STEP_EN
  logic                Step;
`endif
  logic                PC_clr;
  logic                PC_up;
  logic                IR_ld;
  logic [D_ADDR_W-1:0] D_addr;
  logic                D_wr;
  logic                RF_s;
  logic [3:0]          RF_W_addr;
  logic                RF_W_en;
  logic [3:0]          RF_Ra_addr;
  logic [3:0]          RF_Rb_addr;
  logic [2:0]          ALU_s0;
  logic                Halt;

  modport master (
    input  IR,
`ifdef CTRL_STEP_EN
    input  Step,
`endif
    output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, Halt
  );

  modport slave (
    output IR,
`ifdef CTRL_STEP_EN
    output Step,
`endif
    input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, Halt
  );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: Moore sequencer for the processor datapath.
// Fetch -> Decode -> execute (1 cycle, 2 for LOAD) -> Fetch.
// The 4-bit state register is the only flop; every output is a decode of the
// state and IR fields. Clr is an asynchronous, active-high return to Init.
// Build option CTRL_STEP_EN: adds the Step input and a Wait state entered
// after Init and after every execute state; Wait releases to Fetch on Step.
module control_fsm #(
  parameter int ADDR_W   = 7,
  parameter int OP_W     = 4,
  parameter int D_ADDR_W = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  control_fsm_if.master    bus
);

  // The field slicing below assumes the 16-bit IR layout.
  if (OP_W != 4 || D_ADDR_W != 8 || ADDR_W < 1) begin : g_param_chk
    $error("control_fsm: unsupported parameter combination");
  end

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
`ifdef CTRL_STEP_EN
    ,S_WAIT  = 4'd10
`endif
  } state_t;

  // Where Init and every execute state go next.
`ifdef CTRL_STEP_EN
  localparam state_t S_DONE = S_WAIT;
`else
  localparam state_t S_DONE = S_FETCH;
`endif

  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5);

  state_t             r_state;
  state_t             w_next;
  logic [OP_W-1:0]    w_op;

  assign w_op = bus.IR[15 -: OP_W];

  // State register; Clr forces Init without waiting for an edge.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= S_INIT;
    else     r_state <= w_next;
  end

  // Next-state decode; unknown encodings fall back to Init.
  always_comb begin
    w_next = S_INIT;
    case (r_state)
      S_INIT:   w_next = S_DONE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_STORE: w_next = S_STORE;
          OP_LOAD:  w_next = S_LOAD_A;
          OP_ADD:   w_next = S_ADD;
          OP_SUB:   w_next = S_SUB;
          OP_HALT:  w_next = S_HALT;
          default:  w_next = S_NOOP;   // 0000 and undefined opcodes
        endcase
      end
      S_NOOP:   w_next = S_DONE;
      S_STORE:  w_next = S_DONE;
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_DONE;
      S_ADD:    w_next = S_DONE;
      S_SUB:    w_next = S_DONE;
      S_HALT:   w_next = S_HALT;
`ifdef CTRL_STEP_EN
      S_WAIT:   w_next = bus.Step ? S_FETCH : S_WAIT;
`endif
      default:  w_next = S_INIT;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = 4'd0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = 4'd0;
    bus.RF_Rb_addr = 4'd0;
    bus.ALU_s0     = 3'b000;
    bus.Halt       = 1'b0;
    case (r_state)
      S_INIT:  bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_STORE: begin
        bus.D_addr     = bus.IR[11:4];
        bus.RF_Ra_addr = bus.IR[3:0];
        bus.D_wr       = 1'b1;
      end
      // Load_A only addresses memory; the write lands in Load_B once the
      // synchronous read data is available.
      S_LOAD_A, S_LOAD_B: begin
        bus.D_addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
        bus.RF_W_en   = (r_state == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.RF_Rb_addr = bus.IR[7:4];
        bus.RF_W_addr  = bus.IR[3:0];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT:  bus.Halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm. The reference model describes each
// instruction as the list of control vectors it should produce cycle by cycle
// after its Fetch, and the bench walks the DUT through that list.
// Works in both builds (CTRL_STEP_EN defined or not).
module tb_control_fsm;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halt;
  } outs_t;

  logic  Clk = 1'b0;
  logic  Clr;
  int    n_chk  = 0;
  int    n_fail = 0;
  outs_t exp_q[$];
  outs_t w_got;

  control_fsm_if bus();

  control_fsm dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  assign w_got = '{pc_clr: bus.PC_clr, pc_up: bus.PC_up, ir_ld: bus.IR_ld,
                   d_addr: bus.D_addr, d_wr: bus.D_wr, rf_s: bus.RF_s,
                   wa: bus.RF_W_addr, wen: bus.RF_W_en, ra: bus.RF_Ra_addr,
                   rb: bus.RF_Rb_addr, alu: bus.ALU_s0, halt: bus.Halt};

  task automatic chk(input string tag, input outs_t got, input outs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t v_init();
    outs_t o = '0;
    o.pc_clr = 1'b1;
    return o;
  endfunction

  function automatic outs_t v_fetch();
    outs_t o = '0;
    o.pc_up = 1'b1;
    o.ir_ld = 1'b1;
    return o;
  endfunction

  // Expected vectors from the cycle after Fetch (Decode) through the last
  // execute cycle, straight from the instruction semantics.
  task automatic build_seq(input logic [15:0] ir);
    outs_t o = '0;
    exp_q.delete();
    exp_q.push_back('0);                        // Decode
    case (ir[15:12])
      4'd1: begin                               // STORE
        o.d_addr = ir[11:4]; o.ra = ir[3:0]; o.d_wr = 1'b1;
        exp_q.push_back(o);
      end
      4'd2: begin                               // LOAD: address, then write
        o.d_addr = ir[11:4]; o.rf_s = 1'b1; o.wa = ir[3:0];
        exp_q.push_back(o);
        o.wen = 1'b1;
        exp_q.push_back(o);
      end
      4'd3, 4'd4: begin                         // ADD / SUB
        o.ra = ir[11:8]; o.rb = ir[7:4]; o.wa = ir[3:0]; o.wen = 1'b1;
        o.alu = (ir[15:12] == 4'd3) ? 3'b001 : 3'b010;
        exp_q.push_back(o);
      end
      default: exp_q.push_back('0);             // NOOP and undefined
    endcase
  endtask

  // Entered just after Clr is released (one tick past a rising edge).
  task automatic after_reset();
    @(negedge Clk); chk("init", w_got, v_init());
`ifdef CTRL_STEP_EN
    @(negedge Clk); chk("wait_init", w_got, '0);
`endif
    @(negedge Clk); chk("fetch_rst", w_got, v_fetch());
  endtask

  // Entered at the falling edge of a Fetch cycle; leaves at the falling edge
  // of the next Fetch cycle. hold = extra Wait cycles with Step low.
  task automatic run_instr(input logic [15:0] ir, input int hold);
    outs_t e;
    @(posedge Clk); #1 bus.IR = ir;             // IR loads on the Fetch edge
    build_seq(ir);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      @(negedge Clk); chk("exec", w_got, e);
    end
`ifdef CTRL_STEP_EN
    bus.Step = (hold == 0);
    @(negedge Clk); chk("wait", w_got, '0);
    for (int k = 0; k < hold; k++) begin
      @(negedge Clk); chk("wait_hold", w_got, '0);
    end
    bus.Step = 1'b1;
`else
    if (hold < 0) $display("negative hold ignored");
`endif
    @(negedge Clk); chk("fetch", w_got, v_fetch());
  endtask

  initial begin
    outs_t e;
    logic [15:0] ir;
    logic [3:0]  op;
    Clr    = 1'b1;
    bus.IR = 16'h0000;
`ifdef CTRL_STEP_EN
    bus.Step = 1'b1;
`endif
    repeat (2) begin
      @(negedge Clk); chk("rst", w_got, v_init());
    end
    @(posedge Clk); #1 Clr = 1'b0;
    after_reset();

    // Directed instructions, then a random stream (HALT kept for the end).
    run_instr(16'h3125, 0);
    run_instr(16'h21A3, 0);
    run_instr(16'h1074, 0);
    run_instr(16'h9000, 0);
    run_instr(16'h4C3F, 0);
    run_instr(16'h3125, 10);                    // holds in Wait when stepping
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd5) op = op + 4'd1;
      ir = {op, 12'($urandom)};
      run_instr(ir, 0);
    end

    // Clr in the middle of Load_B: the write enable must drop at once.
    @(posedge Clk); #1 bus.IR = 16'h2FF6;
    build_seq(16'h2FF6);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      @(negedge Clk); chk("ld_pre_clr", w_got, e);
    end
    #2 Clr = 1'b1;
    #1 chk("clr_mid_load", w_got, v_init());
    @(posedge Clk); #1 Clr = 1'b0;
    after_reset();

    // HALT holds for 20 cycles, then an off-edge Clr pulse recovers.
    @(posedge Clk); #1 bus.IR = 16'h5000;
    @(negedge Clk); chk("halt_decode", w_got, '0);
    e = '0; e.halt = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk); chk("halt", w_got, e);
    end
    @(posedge Clk); #3 Clr = 1'b1;
    #1 chk("clr_async", w_got, v_init());
    @(posedge Clk); #1 Clr = 1'b0;
    after_reset();
    run_instr(16'h3125, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Moore state machine that sequences the processor datapath.
- Drives the program counter (clear and count-up), the instruction register load, data memory read/write, register-file write and port selects, and the ALU function select.
- Sits between the program counter / instruction register and the datapath.
- One instruction completes every 3–4 clock cycles.

Parameters:
ADDR_W, 7, program counter width (matches PC mem_addr)
OP_W, 4, opcode width, IR[15:12]
D_ADDR_W, 8, data memory address width, IR[11:4]

Ports:
Clk  input  1  system clock, rising edge
Clr  input  1  asynchronous active-high reset; forces state Init
IR  input  16  current instruction register contents
PC_clr  output  1  clears program counter
PC_up  output  1  program counter count enable
IR_ld  output  1  instruction register load enable
D_addr  output  8  data memory address = IR[11:4] during Load/Store, else 0
D_wr  output  1  data memory write enable
RF_s  output  1  register-file write mux: 1 = data memory, 0 = ALU
RF_W_addr  output  4  register-file write address = IR[3:0]
RF_W_en  output  1  register-file write enable
RF_Ra_addr  output  4  port A read address
RF_Rb_addr  output  4  port B read address
ALU_s0  output  3  ALU function: 000 pass-A/idle, 001 add, 010 sub
Halt  output  1  high while in Halt state

Behaviour:
- State register is 4-bit and the only flop. Clr is asynchronous and overrides everything. Reset state is Init.
- All outputs are combinational decodes of the state plus IR fields (Moore). Outputs not listed for a state are 0.
- Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. Any other opcode is executed as NOOP.
- Init: PC_clr=1. Next state: Fetch.
- Fetch: IR_ld=1, PC_up=1. IR captures the instruction at the current PC; PC increments on the same edge. Next state: Decode.
- Decode: all outputs 0. Branches on IR[15:12] to NOOP, Store, Load_A, Add, Sub or Halt.
- NOOP: outputs 0. Next state: Fetch.
- Store: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1. Next state: Fetch.
- Load_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. Covers the one-cycle memory read latency. Next state: Load_B.
- Load_B: same outputs as Load_A plus RF_W_en=1. Next state: Fetch.
- Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], ALU_s0=001, RF_W_en=1, RF_s=0. Next state: Fetch.
- Sub: same as Add but ALU_s0=010.
- Halt: Halt=1, PC_up=0, IR_ld=0. Stays in Halt until Clr.
- Cycle counts from Fetch entry: NOOP/ADD/SUB/STORE 3 cycles, LOAD 4 cycles.
- PC_up is high only in Fetch, so the PC advances exactly once per instruction. Wrap from 127 to 0 is the PC's concern; the FSM does not detect it.
- Clr asserted mid-instruction: state goes to Init immediately, with no edge required. Any in-flight write is abandoned because its enable drops asynchronously. The first Fetch after Clr release reads address 0.
- IR must be stable from Decode through the end of the execute state. IR changes only under IR_ld.
- Unreachable state encodings go to Init on the next edge.

Optional Feature:
- Macro: CTRL_STEP_EN.
- Defined:
  - Adds input Step (1 bit) and state Wait.
  - Every execute state transitions to Wait instead of Fetch.
  - Wait has all outputs 0 and moves to Fetch on the first edge where Step=1, otherwise holds.
  - Init also goes to Wait, so the first instruction needs one Step.
- Undefined: no Step port and no Wait state; behaviour exactly as above.

Test Plan:
- Clr=1 for 2 cycles, release -> state Init for one cycle with PC_clr=1, then Fetch with IR_ld=1, PC_up=1.
- IR=16'h3125 (ADD) -> Decode, then one cycle with RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=5, ALU_s0=001, RF_W_en=1, then Fetch; 3 cycles Fetch-to-Fetch.
- IR=16'h21A3 (LOAD) -> Load_A with D_addr=8'h1A, RF_s=1, RF_W_en=0; Load_B with RF_W_en=1, RF_W_addr=3; 4 cycles total.
- IR=16'h1074 (STORE) -> D_addr=8'h07, RF_Ra_addr=4, D_wr=1 for exactly one cycle. IR=16'h9000 executes as NOOP with no enables high.
- IR=16'h5000 (HALT) -> Halt=1 and PC_up=0 held for 20 cycles. Then Clr pulsed mid-cycle (not on an edge) -> Halt=0 and PC_clr=1 asynchronously.
- With CTRL_STEP_EN, Step=0 for 10 cycles after an ADD -> held in Wait with PC_up=0. Step=1 -> Fetch on the next edge.
